serv_mem_if_w: RTL and testbench

- Parametrised successor to the SERV memory interface: a W-bit serial load/store data path between core (bufreg2/rd) and 32-bit data bus.
- Store: shifts rs2 in W bits/beat, replicates bytes by access size, drives one bus request.
- Load: captures the bus word on ack, right-aligns it by address LSBs, sign/zero-extends it and shifts it out W bits/beat to rd.
- Owns a beat counter and request state machine; no external bytecnt needed.

---
 rtl/serv_mem_pkg.sv | 36 +++
 rtl/serv_mem_lane_sel.sv | 28 ++
 rtl/serv_mem_if_w.sv | 146 ++++++++++++++
 tb/tb_serv_mem_if_w.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_mem_pkg.sv
// serv_mem_pkg: shared types and helpers for the serial memory interface.
package serv_mem_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_IN  = 2'd1,
    ST_REQ       = 2'd2,
    ST_SHIFT_OUT = 2'd3
  } state_e;

  // Force the byte offset onto the natural alignment of the access size.
  function automatic logic [1:0] align_lsb(input logic [1:0] lsb,
                                           input logic       half,
                                           input logic       word_sz);
    if (word_sz)   return 2'b00;
    else if (half) return {lsb[1], 1'b0};
    else           return lsb;
  endfunction

  // Right-align the addressed bytes of a bus word and extend to 32 bits.
  function automatic logic [WORD_BITS-1:0] extend_load(input logic [WORD_BITS-1:0] word,
                                                       input logic [1:0]           lsb,
                                                       input logic                 half,
                                                       input logic                 word_sz,
                                                       input logic                 sgn);
    logic [WORD_BITS-1:0] sh;
    sh = word >> (BYTE_BITS * 32'(lsb));
    if (word_sz)   return sh;
    else if (half) return {{16{sgn & sh[15]}}, sh[15:0]};
    else           return {{24{sgn & sh[7]}}, sh[7:0]};
  endfunction

endpackage

// File: rtl/serv_mem_lane_sel.sv
// serv_mem_lane_sel: byte-lane select and store-data replication for the data bus.
module serv_mem_lane_sel
  import serv_mem_pkg::*;
(
  input  logic [1:0]           lsb_i,
  input  logic                 word_i,
  input  logic                 half_i,
  input  logic [WORD_BITS-1:0] buf_i,
  output logic [3:0]           sel_o,
  output logic [WORD_BITS-1:0] dat_o
);

  // Lanes touched by the access at the given byte offset.
  always_comb begin
    sel_o[0] = (lsb_i == 2'd0);
    sel_o[1] = (lsb_i == 2'd1) | word_i | (half_i & ~lsb_i[1]);
    sel_o[2] = (lsb_i == 2'd2) | word_i;
    sel_o[3] = (lsb_i == 2'd3) | word_i | (half_i & lsb_i[1]);
  end

  // Replicate the low byte/halfword so every selected lane carries the data.
  always_comb begin
    if (word_i)      dat_o = buf_i;
    else if (half_i) dat_o = {2{buf_i[15:0]}};
    else             dat_o = {4{buf_i[7:0]}};
  end

endmodule

// File: rtl/serv_mem_if_w.sv
// serv_mem_if_w: W-bit serial load/store path between core and a 32-bit data bus.
// Optional misaligned-access trap enabled by defining SERV_MEM_IF_W_MISALIGN_TRAP_EN.
module serv_mem_if_w
  import serv_mem_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ld_start,
  input  logic         i_st_start,
  input  logic         i_cnt_en,
  input  logic [1:0]   i_lsb,
  input  logic         i_word,
  input  logic         i_half,
  input  logic         i_signed,
  input  logic [W-1:0] i_rs2,
  input  logic [31:0]  i_dbus_rdt,
  input  logic         i_dbus_ack,
  output logic         o_dbus_cyc,
  output logic         o_dbus_we,
  output logic [31:0]  o_dbus_dat,
  output logic [3:0]   o_dbus_sel,
  output logic [W-1:0] o_rd,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_misalign
);

  localparam int unsigned     BEATS = WORD_BITS / W;
  localparam int unsigned     CW    = $clog2(BEATS);
  localparam logic [CW-1:0]   LAST  = CW'(BEATS - 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("serv_mem_if_w: W must be 1, 2, 4 or 8");
  end

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic [1:0]           lsb_eff;
  logic                 start_ok;

`ifdef SERV_MEM_IF_W_MISALIGN_TRAP_EN
  assign o_misalign = (i_lsb[0] & (i_word | i_half)) | (i_lsb[1] & i_word);
`else
  assign o_misalign = 1'b0;
`endif

  // Misaligned starts are refused only when the trap is built in; otherwise
  // the offset is simply snapped to the access size below.
  assign start_ok = ~o_misalign;
  assign lsb_eff  = align_lsb(i_lsb, i_half, i_word);

  // Next-state logic for the request FSM, shift buffer and beat counter.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok && i_st_start) begin
          state_d = ST_SHIFT_IN;
          cnt_d   = '0;
          we_d    = 1'b1;
        end else if (start_ok && i_ld_start) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          we_d    = 1'b0;
        end
      end
      ST_SHIFT_IN: begin
        if (i_cnt_en) begin
          buf_d = {i_rs2, buf_q[WORD_BITS-1:W]};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_REQ: begin
        if (i_dbus_ack) begin
          if (we_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            buf_d   = extend_load(i_dbus_rdt, lsb_eff, i_half, i_word, i_signed);
            state_d = ST_SHIFT_OUT;
          end
        end
      end
      ST_SHIFT_OUT: begin
        if (i_cnt_en) begin
          buf_d = buf_q >> W;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  serv_mem_lane_sel u_lane_sel (
    .lsb_i  (lsb_eff),
    .word_i (i_word),
    .half_i (i_half),
    .buf_i  (buf_q),
    .sel_o  (o_dbus_sel),
    .dat_o  (o_dbus_dat)
  );

  assign o_dbus_cyc = (state_q == ST_REQ);
  assign o_dbus_we  = o_dbus_cyc & we_q;
  assign o_rd       = (state_q == ST_SHIFT_OUT) ? buf_q[W-1:0] : '0;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;

endmodule

// File: tb/tb_serv_mem_if_w.sv
// tb_serv_mem_if_w: scoreboard bench for serv_mem_if_w with a randomised bus responder.
module tb_serv_mem_if_w;

  localparam int unsigned W     = 4;
  localparam int unsigned BEATS = 32 / W;
`ifdef SERV_MEM_IF_W_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, ld_start, st_start, cnt_en, word, half, sgn;
  logic [1:0]   lsb;
  logic [W-1:0] rs2;
  logic [31:0]  rdt;
  logic         resp_ack, stray_ack, ack;
  logic         cyc, we, busy, done, misalign;
  logic [31:0]  dat;
  logic [3:0]   sel;
  logic [W-1:0] rd;

  assign ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  serv_mem_if_w #(.W(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ld_start (ld_start),
    .i_st_start (st_start),
    .i_cnt_en   (cnt_en),
    .i_lsb      (lsb),
    .i_word     (word),
    .i_half     (half),
    .i_signed   (sgn),
    .i_rs2      (rs2),
    .i_dbus_rdt (rdt),
    .i_dbus_ack (ack),
    .o_dbus_cyc (cyc),
    .o_dbus_we  (we),
    .o_dbus_dat (dat),
    .o_dbus_sel (sel),
    .o_rd       (rd),
    .o_busy     (busy),
    .o_done     (done),
    .o_misalign (misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int unsigned total = 0, bad = 0;
  int unsigned exp_done = 0, seen_done = 0;
  logic        hold_ack = 1'b0;
  logic        cur_we = 1'b0;
  logic        use_forced = 1'b0;
  logic [31:0] forced_rdt = '0;
  int unsigned forced_delay = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---- reference model: access size in bytes, natural alignment, extension ----
  function automatic int unsigned acc_size(input logic w, input logic h);
    return w ? 4 : (h ? 2 : 1);
  endfunction

  function automatic logic natural_mis(input logic [1:0] l, input logic w, input logic h);
    return (int'(l) % acc_size(w, h)) != 0;
  endfunction

  function automatic logic model_misalign(input logic [1:0] l, input logic w, input logic h);
    return TRAP && natural_mis(l, w, h);
  endfunction

  function automatic int unsigned eff_off(input logic [1:0] l, input logic w, input logic h);
    int unsigned sz;
    sz = acc_size(w, h);
    return int'(l) - (int'(l) % sz);
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] l, input logic w, input logic h);
    int unsigned lanes;
    lanes = ((1 << acc_size(w, h)) - 1) << eff_off(l, w, h);
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] model_dat(input logic [31:0] d, input logic w, input logic h);
    if (w)      return d;
    else if (h) return (d & 32'h0000FFFF) * 32'h00010001;
    else        return (d & 32'h000000FF) * 32'h01010101;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] l,
                                             input logic w, input logic h, input logic s);
    int unsigned sz;
    logic [31:0] v, mask, top;
    sz = acc_size(w, h);
    v  = d >> (8 * eff_off(l, w, h));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = v & mask;
    top  = v >> (8 * sz - 1);
    if (s && top == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // ---- bus responder: acks each request after a delay, records load expectations ----
  initial begin : responder
    int unsigned wait_cnt;
    logic        armed;
    logic [31:0] data;
    resp_ack = 1'b0;
    rdt      = '0;
    wait_cnt = 0;
    armed    = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (!cyc || hold_ack || rst) begin
        armed = 1'b0;
      end else begin
        if (!armed) begin
          armed    = 1'b1;
          wait_cnt = use_forced ? forced_delay : $urandom_range(0, 4);
        end
        if (wait_cnt == 0) begin
          data     = use_forced ? forced_rdt : $urandom;
          rdt      = data;
          resp_ack = 1'b1;
          armed    = 1'b0;
          if (!cur_we) rd_q.push_back(model_load(data, lsb, word, half, sgn));
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---- monitor: pops expectations when the bus completes and while rd streams ----
  initial begin : monitor
    logic        collect;
    int unsigned beat;
    logic [31:0] exp_word, tmp;
    req_t        r;
    collect  = 1'b0;
    beat     = 0;
    exp_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        collect = 1'b0;
        continue;
      end
      check("misalign", 32'(misalign), 32'(model_misalign(lsb, word, half)));
      if (done) seen_done++;
      if (ack && cyc) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got cyc=%0b we=%0b want no request", cyc, we);
        end else begin
          r = req_q.pop_front();
          check("we", 32'(we), 32'(r.we));
          if (r.we) begin
            check("dat", dat, r.dat);
            check("sel", 32'(sel), 32'(r.sel));
          end else if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL load_expect: got no expected word want one");
          end else begin
            exp_word = rd_q.pop_front();
            collect  = 1'b1;
            beat     = 0;
          end
        end
      end else if (collect) begin
        tmp = exp_word >> (beat * W);
        check("rd_beat", 32'(rd), 32'(tmp[W-1:0]));
        if (cnt_en) begin
          beat++;
          if (beat == BEATS) collect = 1'b0;
        end
      end else begin
        check("rd_idle", 32'(rd), 32'd0);
      end
    end
  end

  // ---- stimulus ----
  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (busy && n < 400) begin
      cnt_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL idle_timeout: got busy=%0b want 0", busy);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_q.delete();
      rd_q.delete();
    end
  endtask

  task automatic do_access(input logic st, input logic ld, input logic [1:0] l,
                           input logic w, input logic h, input logic s, input logic [31:0] d);
    req_t        r;
    logic        accepted;
    int unsigned k, guard;
    logic [31:0] sh;
    wait_idle();
    lsb = l; word = w; half = h; sgn = s;
    cur_we   = st;
    accepted = (st || ld) && !model_misalign(l, w, h);
    if (accepted) begin
      r.we  = st;
      r.dat = model_dat(d, w, h);
      r.sel = model_sel(l, w, h);
      req_q.push_back(r);
      exp_done++;
    end
    st_start = st;
    ld_start = ld;
    @(posedge clk); #1;
    st_start = 1'b0;
    ld_start = 1'b0;
    if (!accepted) begin
      check("refused_busy", 32'(busy), 32'd0);
      check("refused_cyc", 32'(cyc), 32'd0);
    end else if (st) begin
      k = 0;
      guard = 0;
      while (k < BEATS && guard < 1000) begin
        sh       = d >> (k * W);
        rs2      = sh[W-1:0];
        cnt_en   = 1'($urandom_range(0, 1));
        ld_start = (k == 1);
        @(posedge clk); #1;
        if (cnt_en) k++;
        guard++;
      end
      ld_start = 1'b0;
    end
    wait_idle();
    @(posedge clk); #1;
    check("done_count", seen_done, exp_done);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; ld_start = 1'b0; st_start = 1'b0; cnt_en = 1'b0;
    lsb = '0; word = 1'b0; half = 1'b0; sgn = 1'b0; rs2 = '0; stray_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // signed byte load from the top lane
    use_forced = 1'b1; forced_rdt = 32'h80A5C31E; forced_delay = 0;
    do_access(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'h0);
    // halfword store to the upper half
    use_forced = 1'b0;
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0000BEEF);
    // word load with a slow ack
    use_forced = 1'b1; forced_rdt = 32'h12345678; forced_delay = 5;
    do_access(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    use_forced = 1'b0;

    // reset while the bus request is outstanding, then a stray ack
    wait_idle();
    hold_ack = 1'b1; cur_we = 1'b0;
    lsb = 2'd0; word = 1'b1; half = 1'b0;
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    check("req_cyc", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cyc", 32'(cyc), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd", 32'(rd), 32'd0);
    rst = 1'b0; hold_ack = 1'b0;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(posedge clk); #1;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_done", seen_done, exp_done);

    // simultaneous starts: the store wins
    do_access(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'hCAFE00A7);
    // word access at offset 2: trapped or snapped to offset 0
    do_access(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int unsigned size_sel;
      size_sel = $urandom_range(0, 2);
      do_access(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
                size_sel == 2, size_sel == 1, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("done_final", seen_done, exp_done);
    check("pending_reqs", req_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
